// File: rtl/note_sequencer_if.sv
// ROM bus between note_sequencer (master) and the note table (slave).
// rom_addr = {song_idx, note_idx}; rom_data = {end, freq, dur}, one cycle after the address.
interface note_sequencer_if #(
   parameter int SONG_W  = 2,
   parameter int NOTE_AW = 6,
   parameter int FREQ_W  = 28,
   parameter int DUR_W   = 28
);
   logic [SONG_W+NOTE_AW-1:0] rom_addr;
   logic [FREQ_W+DUR_W:0]     rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer.sv
// Table-driven note sequencer with built-in square-wave tone generator.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence after every note.
module note_sequencer #(
   parameter int FREQ_W     = 28,
   parameter int DUR_W      = 28,
   parameter int N_SONGS    = 3,
   parameter int SONG_W     = 2,
   parameter int NOTE_AW    = 6,
   parameter int GAP_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause_toggle,
   input  logic              next_song,
   input  logic              prev_song,
   input  logic              loop_en,
   note_sequencer_if.master  rom,
   output logic              tone_out,
   output logic [FREQ_W-1:0] freq_out,
   output logic              note_strobe,
   output logic [SONG_W-1:0] song_idx,
   output logic              playing,
   output logic              song_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_PLAY  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(N_SONGS - 1);

   state_t                    state_q, state_d;
   logic                      paused_q, paused_d;
   logic [SONG_W-1:0]         song_q, song_d;
   logic [NOTE_AW-1:0]        note_q, note_d;
   logic [FREQ_W-1:0]         freq_q, freq_d;
   logic [FREQ_W-1:0]         tcnt_q, tcnt_d;
   logic [DUR_W-1:0]          dur_q, dur_d;
   logic                      strobe_q, strobe_d;
   logic                      wrap_done_q, wrap_done_d;
   logic                      tone_q, tone_d;
   logic                      playing_q, playing_d;
   logic [SONG_W+NOTE_AW-1:0] addr_q;

   logic                      rom_end_s;
   logic [FREQ_W-1:0]         rom_freq_s;
   logic [DUR_W-1:0]          rom_dur_s;
   logic                      end_hit_s;
   logic [SONG_W-1:0]         song_inc_s;
   logic [SONG_W-1:0]         song_dec_s;

`ifdef NOTE_GAP_EN
   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   logic [GAP_W-1:0]          gap_q, gap_d;
`endif

   assign rom_end_s  = rom.rom_data[FREQ_W+DUR_W];
   assign rom_freq_s = rom.rom_data[FREQ_W+DUR_W-1:DUR_W];
   assign rom_dur_s  = rom.rom_data[DUR_W-1:0];
   assign song_inc_s = (song_q == LAST_SONG) ? {SONG_W{1'b0}} : song_q + SONG_W'(1);
   assign song_dec_s = (song_q == {SONG_W{1'b0}}) ? LAST_SONG : song_q - SONG_W'(1);

   // The end marker is only visible while LOAD holds the ROM word, so it is flagged combinationally.
   assign end_hit_s  = (state_q == S_LOAD) && !paused_q && rom_end_s;

   // Next-state logic: sequencing, pause freeze and song skips.
   always_comb begin
      state_d     = state_q;
      song_d      = song_q;
      note_d      = note_q;
      freq_d      = freq_q;
      tcnt_d      = tcnt_q;
      dur_d       = dur_q;
      strobe_d    = 1'b0;
      wrap_done_d = 1'b0;
`ifdef NOTE_GAP_EN
      gap_d       = gap_q;
`endif
      paused_d = ((state_q != S_IDLE) && pause_toggle) ? ~paused_q : paused_q;

      if (next_song || prev_song) begin
         // Skips win over everything, including an end-of-song advance in the same cycle.
         song_d  = next_song ? song_inc_s : song_dec_s;
         note_d  = {NOTE_AW{1'b0}};
         state_d = (state_q == S_IDLE) ? S_IDLE : S_FETCH;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) state_d = S_FETCH;
               else       state_d = S_IDLE;
            end
            S_FETCH: begin
               if (!paused_q) state_d = S_LOAD;
               else           state_d = S_FETCH;
            end
            S_LOAD: begin
               if (paused_q) begin
                  state_d = S_LOAD;
               end else if (rom_end_s) begin
                  note_d  = {NOTE_AW{1'b0}};
                  song_d  = loop_en ? song_q : song_inc_s;
                  state_d = S_FETCH;
               end else begin
                  freq_d   = rom_freq_s;
                  dur_d    = (rom_dur_s == {DUR_W{1'b0}}) ? DUR_W'(1) : rom_dur_s;
                  tcnt_d   = {FREQ_W{1'b0}};
                  strobe_d = 1'b1;
                  state_d  = S_PLAY;
               end
            end
            S_PLAY: begin
               if (paused_q) begin
                  state_d = S_PLAY;
               end else if (dur_q <= DUR_W'(1)) begin
                  note_d = note_q + NOTE_AW'(1);
                  // Running off the end of the song's address space counts as an end marker.
                  if (note_q == {NOTE_AW{1'b1}}) begin
                     wrap_done_d = 1'b1;
                     song_d      = loop_en ? song_q : song_inc_s;
                  end else begin
                     wrap_done_d = 1'b0;
                  end
`ifdef NOTE_GAP_EN
                  if (GAP_CYCLES == 0) begin
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_GAP;
                     gap_d   = GAP_W'(GAP_CYCLES);
                  end
`else
                  state_d = S_FETCH;
`endif
               end else begin
                  dur_d  = dur_q - DUR_W'(1);
                  tcnt_d = ((freq_q <= FREQ_W'(1)) || (tcnt_q >= freq_q - FREQ_W'(1)))
                           ? {FREQ_W{1'b0}} : tcnt_q + FREQ_W'(1);
               end
            end
`ifdef NOTE_GAP_EN
            S_GAP: begin
               if (paused_q)                   state_d = S_GAP;
               else if (gap_q <= GAP_W'(1))    state_d = S_FETCH;
               else                            gap_d   = gap_q - GAP_W'(1);
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are computed from next-state values so that they can be registered without lag.
      tone_d    = (state_d == S_PLAY) && !paused_d && (freq_d > FREQ_W'(1)) && (tcnt_d < (freq_d >> 1));
      playing_d = (state_d != S_IDLE) && !paused_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         paused_q    <= 1'b0;
         song_q      <= {SONG_W{1'b0}};
         note_q      <= {NOTE_AW{1'b0}};
         freq_q      <= {FREQ_W{1'b0}};
         tcnt_q      <= {FREQ_W{1'b0}};
         dur_q       <= {DUR_W{1'b0}};
         strobe_q    <= 1'b0;
         wrap_done_q <= 1'b0;
         tone_q      <= 1'b0;
         playing_q   <= 1'b0;
         addr_q      <= {(SONG_W+NOTE_AW){1'b0}};
`ifdef NOTE_GAP_EN
         gap_q       <= {GAP_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         paused_q    <= paused_d;
         song_q      <= song_d;
         note_q      <= note_d;
         freq_q      <= freq_d;
         tcnt_q      <= tcnt_d;
         dur_q       <= dur_d;
         strobe_q    <= strobe_d;
         wrap_done_q <= wrap_done_d;
         tone_q      <= tone_d;
         playing_q   <= playing_d;
         addr_q      <= {song_d, note_d};
`ifdef NOTE_GAP_EN
         gap_q       <= gap_d;
`endif
      end
   end

   assign rom.rom_addr = addr_q;
   assign tone_out     = tone_q;
   assign freq_out     = freq_q;
   assign note_strobe  = strobe_q;
   assign song_idx     = song_q;
   assign playing      = playing_q;
   assign song_done    = end_hit_s | wrap_done_q;

endmodule
